// File: rtl/bram_arb_pkg.sv
// Shared types and constants for the block-RAM port arbiter.
// Response entries track which requester owns each in-flight access.
package bram_arb_pkg;

  localparam int NUM_REQ    = 2;
  localparam int RD_LATENCY = 2;

  typedef struct packed {
    logic valid;
    logic id;
    logic err;
  } rsp_entry_t;

endpackage

// File: rtl/bram_arb_rr2.sv
// Two-way round-robin grant with a one-bit priority pointer.
// The pointer moves to the losing side after every grant.
module bram_arb_rr2
  import bram_arb_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic ptr;

  always_comb begin
    gnt_o = '0;
    if (!rst_i) begin
      unique case (1'b1)
        req_i[0] && (!req_i[1] || !ptr): gnt_o = 2'b01;
        req_i[1] && (!req_i[0] ||  ptr): gnt_o = 2'b10;
        default: gnt_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr <= 1'b0;
    end else if (gnt_o[0]) begin
      ptr <= 1'b1;
    end else if (gnt_o[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one registered-output BRAM port between two requesters.
// Tracks in-flight responses and clocks REGCE with flush reads.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_REQ-1:0]                  req_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_REQ-1:0]                  we_i,
  input  logic [NUM_REQ-1:0][3:0]             be_i,
  input  logic [NUM_REQ-1:0][31:0]            wdata_i,
  output logic [NUM_REQ-1:0]                  gnt_o,
  output logic [NUM_REQ-1:0]                  rvalid_o,
  output logic                                err_o,
  output logic [31:0]                         rdata_o,
  output logic                                ram_en_o,
  output logic [ADDR_WIDTH-1:0]               ram_addr_o,
  output logic [3:0]                          ram_we_o,
  output logic [31:0]                         ram_wdata_o,
  input  logic [31:0]                         ram_rdata_i
);

  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH+1)'(DEPTH);

  logic                  id;
  logic                  any;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  in_range;
  logic                  issue;
  logic                  flush;
  logic                  issued_q;
  logic [ADDR_WIDTH-1:0] last_addr;
  rsp_entry_t [RD_LATENCY-1:0] pipe;

  bram_arb_rr2 u_rr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i (req_i),
    .gnt_o (gnt_o)
  );

  assign id       = gnt_o[1];
  assign any      = |gnt_o;
  assign addr     = addr_i[id];
  assign in_range = {1'b0, addr} < LIMIT;
  assign issue    = any && in_range;
  // Any cycle without a RAM issue after one needs a REGCE pulse.
  assign flush    = issued_q && !issue;

  always_comb begin
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_we_o    = '0;
    ram_wdata_o = '0;
    if (!rst_i) begin
      if (issue) begin
        ram_en_o    = 1'b1;
        ram_addr_o  = addr;
        ram_we_o    = we_i[id] ? be_i[id] : 4'b0;
        ram_wdata_o = wdata_i[id];
      end else begin
        ram_en_o    = flush;
        ram_addr_o  = last_addr;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      issued_q  <= 1'b0;
      last_addr <= '0;
      pipe      <= '0;
    end else begin
      issued_q <= issue;
      if (issue) begin
        last_addr <= addr;
      end
      pipe[0] <= '{valid: any, id: id, err: any && !in_range};
      pipe[1] <= pipe[0];
    end
  end

  always_comb begin
    rvalid_o = '0;
    err_o    = 1'b0;
    rdata_o  = '0;
    if (pipe[1].valid && !rst_i) begin
      rvalid_o[pipe[1].id] = 1'b1;
      err_o   = pipe[1].err;
      rdata_o = pipe[1].err ? 32'h0 : ram_rdata_i;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural BRAM
// model: 2-cycle latency, output register gated by en, write-first.
module tb_bram_port_arbiter;

  localparam int AW = 11;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req = '0;
  logic [1:0][AW-1:0] addr = '0;
  logic [1:0]       we = '0;
  logic [1:0][3:0]  be = '0;
  logic [1:0][31:0] wdata = '0;
  logic [1:0]       gnt;
  logic [1:0]       rvalid;
  logic             err;
  logic [31:0]      rdata;
  logic             ram_en;
  logic [AW-1:0]    ram_addr;
  logic [3:0]       ram_we;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_rdata;

  logic [31:0] mem [0:2047];
  logic [31:0] lat_q = '0;
  logic [31:0] out_q = '0;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  bram_port_arbiter #(.ADDR_WIDTH(AW), .DEPTH(1024)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .addr_i      (addr),
    .we_i        (we),
    .be_i        (be),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .err_o       (err),
    .rdata_o     (rdata),
    .ram_en_o    (ram_en),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  assign ram_rdata = out_q;

  always @(posedge clk) begin
    if (ram_en) begin
      logic [31:0] w;
      w = mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) w[b*8 +: 8] = ram_wdata[b*8 +: 8];
      if (|ram_we) mem[ram_addr] <= w;
      lat_q <= w;
      out_q <= lat_q;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = '0; we = '0; be = '0; wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    mem[1] = 32'h1111_1111;
    mem[2] = 32'h2222_2222;
    mem[5] = 32'hDEAD_BEEF;
    mem[7] = 32'hFFFF_FFFF;

    // reset state, with requests asserted
    tick();
    req = 2'b11; addr[0] = 11'd5; we = 2'b11; be = '1;
    wdata[0] = 32'hA5A5_A5A5;
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_en", 32'(ram_en), 32'h0);
    check("rst_we", 32'(ram_we), 32'h0);
    check("rst_addr", 32'(ram_addr), 32'h0);
    check("rst_wdata", ram_wdata, 32'h0);
    do_reset();

    // single read of addr 5
    req = 2'b01; addr[0] = 11'd5; #1;
    check("rd_gnt", 32'(gnt), 32'h1);
    check("rd_en", 32'(ram_en), 32'h1);
    check("rd_addr", 32'(ram_addr), 32'd5);
    check("rd_we", 32'(ram_we), 32'h0);
    tick(); idle(); #1;
    check("rd_flush_en", 32'(ram_en), 32'h1);
    check("rd_flush_addr", 32'(ram_addr), 32'd5);
    check("rd_flush_we", 32'(ram_we), 32'h0);
    check("rd_t1_rvalid", 32'(rvalid), 32'h0);
    tick(); #1;
    check("rd_rvalid", 32'(rvalid), 32'h1);
    check("rd_err", 32'(err), 32'h0);
    check("rd_rdata", rdata, 32'hDEAD_BEEF);
    check("rd_idle_en", 32'(ram_en), 32'h0);
    check("rd_idle_addr", 32'(ram_addr), 32'd5);

    // contention, both requesters held four cycles
    do_reset();
    addr[0] = 11'd1; addr[1] = 11'd2;
    for (int k = 0; k < 6; k++) begin
      logic [1:0] ge;
      logic [1:0] re;
      req = (k < 4) ? 2'b11 : 2'b00;
      ge = (k >= 4) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
      re = (k < 2) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
      #1;
      check($sformatf("cn_gnt%0d", k), 32'(gnt), 32'(ge));
      check($sformatf("cn_rvalid%0d", k), 32'(rvalid), 32'(re));
      if (k >= 2)
        check($sformatf("cn_rdata%0d", k), rdata,
              re[0] ? 32'h1111_1111 : 32'h2222_2222);
      if (k == 4) begin
        check("cn_flush_en", 32'(ram_en), 32'h1);
        check("cn_flush_addr", 32'(ram_addr), 32'd2);
      end
      if (k == 5) check("cn_idle_en", 32'(ram_en), 32'h0);
      tick();
    end

    // partial write then read-back of addr 7
    do_reset();
    req = 2'b01; addr[0] = 11'd7; we = 2'b01; be[0] = 4'b0011;
    wdata[0] = 32'h1234_5678; #1;
    check("wr_gnt", 32'(gnt), 32'h1);
    check("wr_we", 32'(ram_we), 32'h3);
    check("wr_wdata", ram_wdata, 32'h1234_5678);
    tick();
    we = '0; be = '0; #1;
    check("wr_rd_gnt", 32'(gnt), 32'h1);
    check("wr_rd_we", 32'(ram_we), 32'h0);
    tick(); idle(); #1;
    check("wr_rvalid", 32'(rvalid), 32'h1);
    check("wr_rdata", rdata, 32'hFFFF_5678);
    tick(); #1;
    check("rb_rvalid", 32'(rvalid), 32'h1);
    check("rb_rdata", rdata, 32'hFFFF_5678);

    // out-of-range access from requester 1
    do_reset();
    req = 2'b10; addr[1] = 11'd1024; #1;
    check("oor_gnt", 32'(gnt), 32'h2);
    check("oor_en", 32'(ram_en), 32'h0);
    check("oor_we", 32'(ram_we), 32'h0);
    tick(); idle(); #1;
    check("oor_t1_en", 32'(ram_en), 32'h0);
    tick(); #1;
    check("oor_rvalid", 32'(rvalid), 32'h2);
    check("oor_err", 32'(err), 32'h1);
    check("oor_rdata", rdata, 32'h0);
    tick(); #1;
    check("oor_after", 32'(rvalid), 32'h0);

    // last in-range word
    do_reset();
    req = 2'b01; addr[0] = 11'd1023; #1;
    check("edge_en", 32'(ram_en), 32'h1);
    tick(); idle(); tick(); #1;
    check("edge_err", 32'(err), 32'h0);
    check("edge_rvalid", 32'(rvalid), 32'h1);

    // reset one cycle after a grant
    do_reset();
    req = 2'b10; addr[1] = 11'd5; #1;
    check("rm_gnt", 32'(gnt), 32'h2);
    tick();
    rst = 1'b1; req = 2'b11; #1;
    check("rm_rst_gnt", 32'(gnt), 32'h0);
    check("rm_rst_en", 32'(ram_en), 32'h0);
    tick();
    rst = 1'b0; req = 2'b00; #1;
    check("rm_rvalid", 32'(rvalid), 32'h0);
    tick(); #1;
    check("rm_rvalid2", 32'(rvalid), 32'h0);
    req = 2'b11; #1;
    check("rm_ptr_gnt", 32'(gnt), 32'h1);
    tick(); idle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
